// File: rtl/rally_pkg.sv
// Shared encodings for the rally scorer: FSM states, ball direction, serve and winner codes.
package rally_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RALLY     = 2'd1,
        ST_POINT     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [1:0] DIR_IDLE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;

    localparam logic [1:0] SERVE_NONE  = 2'b00;
    localparam logic [1:0] SERVE_RIGHT = 2'b01;
    localparam logic [1:0] SERVE_LEFT  = 2'b10;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_RIGHT = 2'b01;
    localparam logic [1:0] WIN_LEFT  = 2'b10;

    // Scores stick at 15 rather than wrapping back to 0.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/rally_scorer_miss_detect.sv
// Flags a missed return: the ball is moving but no court LED is lit.
module miss_detect
    import rally_pkg::*;
(
    input  logic [1:0]  direction,
    input  logic [15:0] light,
    output logic        miss_left,
    output logic        miss_right
);

    logic off_court;

    assign off_court  = (light == 16'h0000);
    assign miss_left  = off_court && (direction == DIR_LEFT);
    assign miss_right = off_court && (direction == DIR_RIGHT);

endmodule

// File: rtl/rally_scorer.sv
// Point/game scoring FSM sitting downstream of the ball stage; issues serves and tracks rally_best.
// Define RALLY_SCORER_DEUCE_EN to require a two-point lead (with deuce fold-back) to win a game.
module rally_scorer
    import rally_pkg::*;
#(
    parameter int WIN_POINTS  = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  direction,
    input  logic [15:0] light,
    input  logic [2:0]  hitnum,
    output logic [1:0]  serve,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        point_flash,
    output logic [2:0]  rally_best
);

    localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]      WIN4      = 4'(WIN_POINTS);

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          last_right;
    logic          miss_left;
    logic          miss_right;

    // Candidate scores if the right (rp_*) or left (lp_*) player takes the point.
    logic [3:0] rp_left, rp_right, lp_left, lp_right;
    logic       left_wins, right_wins;
    logic [2:0] best_next;

    miss_detect u_miss_detect (
        .direction  (direction),
        .light      (light),
        .miss_left  (miss_left),
        .miss_right (miss_right)
    );

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        rp_left  = score_left;
        rp_right = sat_inc(score_right);
        lp_left  = sat_inc(score_left);
        lp_right = score_right;
`ifdef RALLY_SCORER_DEUCE_EN
        if (rp_left == WIN4 && rp_right == WIN4) begin
            rp_left  = WIN4 - 4'd1;
            rp_right = WIN4 - 4'd1;
        end
        if (lp_left == WIN4 && lp_right == WIN4) begin
            lp_left  = WIN4 - 4'd1;
            lp_right = WIN4 - 4'd1;
        end
        left_wins  = (score_left >= WIN4) &&
                     ({1'b0, score_left} >= {1'b0, score_right} + 5'd2);
        right_wins = (score_right >= WIN4) &&
                     ({1'b0, score_right} >= {1'b0, score_left} + 5'd2);
`else
        left_wins  = (score_left >= WIN4);
        right_wins = (score_right >= WIN4);
`endif
        best_next = (hitnum > rally_best) ? hitnum : rally_best;
    end

    assign game_over   = (state == ST_GAME_OVER);
    assign point_flash = (state == ST_POINT);

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            serve       <= SERVE_NONE;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            winner      <= WIN_NONE;
            rally_best  <= 3'd0;
            hold_cnt    <= '0;
            last_right  <= 1'b0;
        end else begin
            serve <= SERVE_NONE;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        score_left  <= 4'd0;
                        score_right <= 4'd0;
                        rally_best  <= 3'd0;
                        winner      <= WIN_NONE;
                        hold_cnt    <= '0;
                        serve       <= SERVE_RIGHT;
                        state       <= ST_RALLY;
                    end
                end
                ST_RALLY: begin
                    if (miss_left) begin
                        score_left  <= rp_left;
                        score_right <= rp_right;
                        rally_best  <= best_next;
                        last_right  <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= ST_POINT;
                    end else if (miss_right) begin
                        score_left  <= lp_left;
                        score_right <= lp_right;
                        rally_best  <= best_next;
                        last_right  <= 1'b0;
                        hold_cnt    <= '0;
                        state       <= ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (left_wins) begin
                            winner <= WIN_LEFT;
                            state  <= ST_GAME_OVER;
                        end else if (right_wins) begin
                            winner <= WIN_RIGHT;
                            state  <= ST_GAME_OVER;
                        end else begin
                            serve <= last_right ? SERVE_RIGHT : SERVE_LEFT;
                            state <= ST_RALLY;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rally_scorer.sv
// Self-checking bench for rally_scorer: directed scenarios plus a random game against a score-level model.
module tb_rally_scorer;

    localparam int WIN  = 7;
    localparam int HOLD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  direction;
    logic [15:0] light;
    logic [2:0]  hitnum;
    logic [1:0]  serve;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic [1:0]  winner;
    logic        game_over;
    logic        point_flash;
    logic [2:0]  rally_best;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integer scores and game-level rules.
    int         m_l, m_r, m_best;
    bit         m_last_right;
    logic [1:0] m_win;

    rally_scorer #(.WIN_POINTS(WIN), .HOLD_CYCLES(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .direction   (direction),
        .light       (light),
        .hitnum      (hitnum),
        .serve       (serve),
        .score_left  (score_left),
        .score_right (score_right),
        .winner      (winner),
        .game_over   (game_over),
        .point_flash (point_flash),
        .rally_best  (rally_best)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] exp_serve,
                             input logic exp_flash, input logic exp_go);
        chk({tag, ".serve"},       16'(serve),       16'(exp_serve));
        chk({tag, ".score_left"},  16'(score_left),  16'(m_l));
        chk({tag, ".score_right"}, 16'(score_right), 16'(m_r));
        chk({tag, ".winner"},      16'(winner),      16'(m_win));
        chk({tag, ".game_over"},   16'(game_over),   16'(exp_go));
        chk({tag, ".point_flash"}, 16'(point_flash), 16'(exp_flash));
        chk({tag, ".rally_best"},  16'(rally_best),  16'(m_best));
    endtask

    task automatic model_clear();
        m_l = 0; m_r = 0; m_best = 0; m_win = 2'b00; m_last_right = 1'b0;
    endtask

    task automatic award(input bit to_right, input logic [2:0] hn);
        if (to_right) m_r = (m_r < 15) ? m_r + 1 : 15;
        else          m_l = (m_l < 15) ? m_l + 1 : 15;
`ifdef RALLY_SCORER_DEUCE_EN
        if (m_l == WIN && m_r == WIN) begin
            m_l = m_l - 1;
            m_r = m_r - 1;
        end
`endif
        if (int'(hn) > m_best) m_best = int'(hn);
        m_last_right = to_right;
    endtask

    function automatic logic [1:0] decide();
`ifdef RALLY_SCORER_DEUCE_EN
        if (m_l >= WIN && m_l - m_r >= 2) return 2'b10;
        if (m_r >= WIN && m_r - m_l >= 2) return 2'b01;
`else
        if (m_l >= WIN) return 2'b10;
        if (m_r >= WIN) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic set_quiet();
        start     = 1'b0;
        direction = 2'b00;
        light     = 16'(1) << $urandom_range(0, 15);
        hitnum    = 3'($urandom_range(0, 7));
    endtask

    // Random inputs that never form a miss; start pulses must be ignored in RALLY.
    task automatic set_noise();
        int kind;
        kind      = $urandom_range(0, 2);
        start     = 1'($urandom_range(0, 1));
        hitnum    = 3'($urandom_range(0, 7));
        if (kind == 0) begin
            direction = 2'b00;
            light     = $urandom_range(0, 1) ? 16'h0000 : 16'($urandom);
        end else begin
            direction = (kind == 1) ? 2'b01 : 2'b10;
            light     = 16'(1) << $urandom_range(0, 15);
        end
    endtask

    task automatic rally_noise(input int n);
        for (int i = 0; i < n; i++) begin
            set_noise();
            tick();
            check_all("rally", 2'b00, 1'b0, 1'b0);
        end
        set_quiet();
    endtask

    task automatic new_game();
        start = 1'b1;
        tick();
        model_clear();
        check_all("start", 2'b01, 1'b0, 1'b0);
        set_quiet();
        tick();
        check_all("serve_once", 2'b00, 1'b0, 1'b0);
    endtask

    task automatic play_point(input bit left_misses, input logic [2:0] hn);
        rally_noise($urandom_range(0, 4));
        direction = left_misses ? 2'b01 : 2'b10;
        light     = 16'h0000;
        hitnum    = hn;
        tick();
        award(left_misses, hn);
        check_all("point_hold", 2'b00, 1'b1, 1'b0);
        for (int i = 1; i < HOLD; i++) begin
            // Miss-shaped inputs and start during the hold must be ignored.
            direction = 2'($urandom_range(1, 2));
            light     = $urandom_range(0, 1) ? 16'h0000 : 16'(1) << $urandom_range(0, 15);
            start     = 1'($urandom_range(0, 1));
            tick();
            check_all("point_hold", 2'b00, 1'b1, 1'b0);
        end
        set_quiet();
        tick();
        m_win = decide();
        if (m_win != 2'b00) begin
            check_all("game_end", 2'b00, 1'b0, 1'b1);
        end else begin
            check_all("next_serve", m_last_right ? 2'b01 : 2'b10, 1'b0, 1'b0);
            tick();
            check_all("serve_pulse_end", 2'b00, 1'b0, 1'b0);
        end
    endtask

    task automatic finish_game();
        for (int i = 0; i < 3; i++) begin
            direction = 2'($urandom_range(0, 2));
            light     = $urandom_range(0, 1) ? 16'h0000 : 16'($urandom);
            start     = 1'b0;
            tick();
            check_all("game_over_hold", 2'b00, 1'b0, 1'b1);
        end
        new_game();
    endtask

    initial begin
        bit deuce_seq [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        model_clear();
        reset = 1'b0; start = 1'b0; direction = 2'b00; light = 16'h0; hitnum = 3'd0;
        tick();
        tick();
        check_all("in_reset", 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_all("idle", 2'b00, 1'b0, 1'b0);
        new_game();

        // Left miss with hitnum 3, then a right miss.
        play_point(1'b1, 3'd3);
        play_point(1'b0, 3'd2);

        // Direction idle with an empty court never scores.
        direction = 2'b00; light = 16'h0000; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("dir_idle_no_miss", 2'b00, 1'b0, 1'b0);
        end

        // Left player keeps missing until the game ends.
        for (int i = 0; i < 20 && m_win == 2'b00; i++)
            play_point(1'b1, 3'($urandom_range(0, 7)));
        chk("left_miss_game_winner", 16'(winner), 16'h1);
        finish_game();

        // Race to 6-6, then 7-7 (deuce fold-back when enabled), then right pulls away.
        for (int i = 0; i < 16 && m_win == 2'b00; i++)
            play_point(deuce_seq[i], 3'($urandom_range(0, 7)));
        if (m_win == 2'b00) begin
            chk("deuce_seq_ended", 16'(game_over), 16'h1);
            rally_noise(2);
        end else begin
            finish_game();
        end

        // Random game.
        if (m_win == 2'b00 && game_over === 1'b0) begin
            for (int i = 0; i < 80 && m_win == 2'b00; i++)
                play_point(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            chk("random_game_ended", 16'(m_win != 2'b00), 16'(game_over));
            if (m_win != 2'b00) finish_game();
        end

        // Reset during the second POINT cycle drops the pending serve.
        rally_noise(2);
        direction = 2'b10; light = 16'h0000; hitnum = 3'd5;
        tick();
        award(1'b0, 3'd5);
        check_all("pre_reset_point", 2'b00, 1'b1, 1'b0);
        set_quiet();
        tick();
        check_all("pre_reset_point2", 2'b00, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_clear();
        check_all("mid_hold_reset", 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < HOLD + 2; i++) begin
            direction = 2'($urandom_range(1, 2)); light = 16'h0000;
            tick();
            check_all("post_reset_idle", 2'b00, 1'b0, 1'b0);
        end
        set_quiet();
        new_game();
        play_point(1'b0, 3'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
